// File: rtl/root_pkg.sv
// root_pkg: shared constants for the iterative integer root engine.
// FSM state encoding, mode encoding and step-count helpers.
package root_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_MUL   = 3'd2;
  localparam logic [2:0] ST_TEST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  // square-root steps; also the width of the root output
  function automatic int ys_f(input int w);
    return (w + 1) / 2;
  endfunction

  // cube-root steps
  function automatic int yc_f(input int w);
    return (w + 2) / 3;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/root_unit_mul_seq.sv
// mul_seq: sequential shift-add multiplier, one multiplier bit per cycle.
// start_i loads the operands; busy_o stays high for exactly N cycles and
// done_o marks the last of them, after which p_o holds a_i*b_i.
module mul_seq #(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] p_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           busy;

  assign busy_o = busy;
  assign done_o = busy && (cnt == CW'(N - 1));
  assign p_o    = acc;

  // load on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start_i) begin
      mcand  <= {{N{1'b0}}, a_i};
      mplier <= b_i;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/root_unit.sv
// root_unit: floor square root / floor cube root of an unsigned WIDTH-bit
// operand, digit-by-digit restoring, one result bit per step.
// Optional feature macro ROOT_REM_EN adds the r_bo remainder output.
module root_unit
  import root_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [WIDTH-1:0]       x_bi,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [ys_f(WIDTH)-1:0] y_bo
`ifdef ROOT_REM_EN
  ,
  output logic [WIDTH-1:0]       r_bo
`endif
);

  localparam int YS = ys_f(WIDTH);
  localparam int YC = yc_f(WIDTH);
  localparam int SW = $clog2(WIDTH + 1);
  // wide enough for x>>s, 2y+1 and 3*y*(y+1)+1 without overflow
  localparam int TW = max_f(WIDTH + 2, 2 * YC + 3);
  localparam logic [SW-1:0] S0_SQ = SW'(2 * (YS - 1));
  localparam logic [SW-1:0] S0_CB = SW'(3 * (YC - 1));

  logic [2:0]       state;
  logic             m;
  logic [WIDTH-1:0] x;
  logic [YS-1:0]    y;
  logic [SW-1:0]    s;

  logic [YS-1:0]     ysh;
  logic [YC:0]       mul_a;
  logic [YC:0]       mul_b;
  logic [2*YC+1:0]   mul_p;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;

  logic [TW-1:0]    p_w;
  logic [TW-1:0]    t;
  logic [TW-1:0]    xs;
  logic             fit;
  logic [WIDTH-1:0] x_sub;
  logic [YS-1:0]    y_inc;

  // the multiplier is started in SHIFT, so it sees the already-doubled y
  assign ysh       = y << 1;
  assign mul_a     = {1'b0, ysh[YC-1:0]};
  assign mul_b     = {1'b0, ysh[YC-1:0]} + (YC+1)'(1);
  assign mul_start = (state == ST_SHIFT) && (m == MODE_CBRT);

  mul_seq #(.N(YC + 1)) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(mul_start),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .busy_o (mul_busy),
    .done_o (mul_done),
    .p_o    (mul_p)
  );

  // trial value and compare; t is never shifted left so it cannot overflow
  always_comb begin
    p_w   = TW'(mul_p);
    t     = (m == MODE_CBRT) ? ((p_w << 1) + p_w + TW'(1)) : TW'({y, 1'b1});
    xs    = TW'(x >> s);
    fit   = (xs >= t);
    x_sub = x - (t[WIDTH-1:0] << s);
    y_inc = y + YS'(1);
  end

  // mul_busy only rises inside MUL, so this is simply "not idle"
  assign busy_o  = (state != ST_IDLE) | mul_busy;
  assign valid_o = (state == ST_DONE);

  // control FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      m     <= MODE_SQRT;
      x     <= '0;
      y     <= '0;
      s     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            x     <= x_bi;
            m     <= mode_i;
            y     <= '0;
            s     <= (mode_i == MODE_CBRT) ? S0_CB : S0_SQ;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          y     <= ysh;
          state <= (m == MODE_CBRT) ? ST_MUL : ST_TEST;
        end
        ST_MUL: begin
          if (mul_done) state <= ST_TEST;
        end
        ST_TEST: begin
          if (fit) begin
            x <= x_sub;
            y <= y_inc;
          end
          if (s == '0) begin
            state <= ST_DONE;
          end else begin
            s     <= s - ((m == MODE_CBRT) ? SW'(3) : SW'(2));
            state <= ST_SHIFT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // result registers load on the last TEST so they are visible with valid_o
  // and hold until the next result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      y_bo <= '0;
`ifdef ROOT_REM_EN
      r_bo <= '0;
`endif
    end else if (state == ST_TEST && s == '0) begin
      y_bo <= fit ? y_inc : y;
`ifdef ROOT_REM_EN
      r_bo <= fit ? x_sub : x;
`endif
    end
  end

endmodule

// File: tb/tb_root_unit.sv
// tb_root_unit: scoreboard bench for root_unit (WIDTH=8).
// Driver pushes reference results computed by brute-force search; a monitor
// pops and compares on every valid_o. r_bo is checked when ROOT_REM_EN is set.
module tb_root_unit;

  localparam int W  = 8;
  localparam int YS = (W + 1) / 2;
  localparam int YC = (W + 2) / 3;
  localparam int LAT_SQ = 2 * YS + 1;
  localparam int LAT_CB = YC * (YC + 3) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [W-1:0]  x_bi = '0;
  logic          busy;
  logic          valid;
  logic [YS-1:0] y_bo;
`ifdef ROOT_REM_EN
  logic [W-1:0]  r_bo;
`endif

  root_unit #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .start_i(start_i),
    .mode_i (mode_i),
    .x_bi   (x_bi),
    .busy_o (busy),
    .valid_o(valid),
    .y_bo   (y_bo)
`ifdef ROOT_REM_EN
    ,
    .r_bo   (r_bo)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int y;
    int r;
    int lat;
    int c0;
  } exp_t;

  exp_t q[$];
  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ipow(input int b, input bit cube);
    return cube ? b * b * b : b * b;
  endfunction

  // largest y with y^k <= x
  function automatic int froot(input bit cube, input int x);
    int y = 0;
    while (ipow(y + 1, cube) <= x) y++;
    return y;
  endfunction

  // drive start for one cycle (called at a negedge) and record the expectation
  task automatic issue(input bit m, input int x);
    exp_t e;
    e.y   = froot(m, x);
    e.r   = x - ipow(e.y, m);
    e.lat = m ? LAT_CB : LAT_SQ;
    e.c0  = cyc;
    q.push_back(e);
    start_i = 1'b1;
    mode_i  = m;
    x_bi    = W'(x);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // wait for valid_o with a bound, counting busy cycles on the way
  task automatic wait_done(input int exp_busy);
    int nb = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) nb++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_timeout", int'(seen), 1);
    if (exp_busy >= 0) chk("busy_cycles", nb, exp_busy);
  endtask

  task automatic do_op(input bit m, input int x);
    @(negedge clk);
    issue(m, x);
    wait_done(m ? LAT_CB : LAT_SQ);
  endtask

  // monitor: every valid_o must match the oldest outstanding request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("y_bo", int'(y_bo), e.y);
`ifdef ROOT_REM_EN
          chk("r_bo", int'(r_bo), e.r);
`endif
          chk("latency", cyc - e.c0, e.lat);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_y", int'(y_bo), 0);
`ifdef ROOT_REM_EN
    chk("rst_r", int'(r_bo), 0);
`endif
    rst_n = 1'b1;

    // directed values, including operand extremes
    do_op(1'b1, 27);
    do_op(1'b1, 255);
    do_op(1'b1, 0);
    do_op(1'b0, 255);
    do_op(1'b0, 144);
    do_op(1'b0, 0);

    // start while busy is ignored: no second result
    @(negedge clk);
    issue(1'b1, 64);
    repeat (4) @(negedge clk);
    start_i = 1'b1;
    mode_i  = 1'b0;
    x_bi    = 8'd8;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(-1);
    repeat (30) @(negedge clk);
    chk("no_second_valid", q.size(), 0);

    // reset mid-operation discards the operation and clears outputs
    @(negedge clk);
    issue(1'b1, 200);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_y", int'(y_bo), 0);
`ifdef ROOT_REM_EN
    chk("midrst_r", int'(r_bo), 0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 200);

    // exhaustive, back-to-back in both modes
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < (1 << W); x++)
        do_op(m[0], x);

    // randomized operands, modes and idle gaps
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << W) - 1)));
    end

    repeat (40) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
